// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcodes, datapath mux codes and the DECODE dispatch helper.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_R_WB      = 4'd3,
      S_MEM_ADDR  = 4'd4,
      S_MEM_READ  = 4'd5,
      S_MEM_WB    = 4'd6,
      S_MEM_WRITE = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11,
      S_TRAP      = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Successor of DECODE for a given opcode; unknown opcodes trap.
   function automatic state_t decode_next(input logic [5:0] op);
      state_t nxt;
      case (op)
         OP_RTYPE:     nxt = S_EXEC_R;
         OP_LW, OP_SW: nxt = S_MEM_ADDR;
         OP_BEQ:       nxt = S_BRANCH;
         OP_J:         nxt = S_JUMP;
         OP_ADDI:      nxt = S_ADDI_EXEC;
         default:      nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// 3-bit wait counter for multi-cycle memory states; done when count reaches MEM_WAIT.
module ctrl_wait_counter #(
   parameter int MEM_WAIT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

   logic [2:0] count_reg;

   // Count up to WAIT_MAX while enabled; clear wins so each state starts at 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg < WAIT_MAX)) begin
         count_reg <= count_reg + 3'd1;
      end
   end

   assign done = (count_reg == WAIT_MAX);

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle control FSM: Moore decode of state plus wait counter into
// every datapath control line. Outputs are forced low while reset is held.
module control_unit_mc
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       i_or_d,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       trap,
   output logic [3:0] state_out
);

   state_t     state_reg, state_next;
   logic [5:0] opcode_reg;
   logic       wait_done;
   logic       wait_clear;
   logic       wait_enable;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= S_FETCH;
      else        state_reg <= state_next;
   end

   // Opcode captured in DECODE so MEM_ADDR can pick load vs store later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    opcode_reg <= '0;
      else if (state_reg == S_DECODE) opcode_reg <= opcode;
   end

   assign wait_clear  = (state_next != state_reg);
   assign wait_enable = (state_reg == S_FETCH) || (state_reg == S_MEM_READ);

   ctrl_wait_counter #(
      .MEM_WAIT (MEM_WAIT)
   ) u_wait (
      .clk    (clk),
      .reset  (reset),
      .clear  (wait_clear),
      .enable (wait_enable),
      .done   (wait_done)
   );

   assign state_out = state_reg;

   // Next-state and Moore output decode; everything defaults to 0.
   always_comb begin
      state_next    = state_reg;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCSRC_ALU;
      i_or_d        = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALUOP_ADD;
      trap          = 1'b0;
      case (state_reg)
         S_FETCH: begin
            alu_src_b = SRCB_FOUR;
            if (wait_done) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b  = SRCB_IMM_SH2;
            state_next = decode_next(opcode);
         end
         S_EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_op     = ALUOP_FUNCT;
            state_next = S_R_WB;
         end
         S_R_WB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            state_next = (opcode_reg == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            i_or_d = 1'b1;
            if (wait_done) state_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WRITE: begin
            i_or_d     = 1'b1;
            mem_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            state_next    = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            state_next = S_FETCH;
         end
         S_ADDI_EXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            state_next = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_next = S_TRAP;
         end
      endcase
      if (!reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         pc_source     = 2'b00;
         i_or_d        = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         trap          = 1'b0;
      end
   end

endmodule

// File: tb/tb_control_unit_mc.sv
// Table-driven bench for control_unit_mc with MEM_WAIT = 1, 2 and 0 instances.
module tb_control_unit_mc;
   import cpu_ctrl_pkg::*;

   localparam int NDUT = 3;

   // Control word: pcw pcwc pcsrc[2] iord memw irw regdst m2r regw srca srcb[2] aluop[2] trap
   localparam logic [15:0] C_ZERO   = 16'b0_0_00_0_0_0_0_0_0_0_00_00_0;
   localparam logic [15:0] C_FW     = 16'b0_0_00_0_0_0_0_0_0_0_01_00_0;
   localparam logic [15:0] C_FL     = 16'b1_0_00_0_0_1_0_0_0_0_01_00_0;
   localparam logic [15:0] C_DEC    = 16'b0_0_00_0_0_0_0_0_0_0_11_00_0;
   localparam logic [15:0] C_EXR    = 16'b0_0_00_0_0_0_0_0_0_1_00_10_0;
   localparam logic [15:0] C_RWB    = 16'b0_0_00_0_0_0_1_0_1_0_00_00_0;
   localparam logic [15:0] C_MADDR  = 16'b0_0_00_0_0_0_0_0_0_1_10_00_0;
   localparam logic [15:0] C_MRD    = 16'b0_0_00_1_0_0_0_0_0_0_00_00_0;
   localparam logic [15:0] C_MWB    = 16'b0_0_00_0_0_0_0_1_1_0_00_00_0;
   localparam logic [15:0] C_MWR    = 16'b0_0_00_1_1_0_0_0_0_0_00_00_0;
   localparam logic [15:0] C_BR     = 16'b0_1_01_0_0_0_0_0_0_1_00_01_0;
   localparam logic [15:0] C_JMP    = 16'b1_0_10_0_0_0_0_0_0_0_00_00_0;
   localparam logic [15:0] C_AEX    = 16'b0_0_00_0_0_0_0_0_0_1_10_00_0;
   localparam logic [15:0] C_AWB    = 16'b0_0_00_0_0_0_0_0_1_0_00_00_0;
   localparam logic [15:0] C_TRAP   = 16'b0_0_00_0_0_0_0_0_0_0_00_00_1;

   localparam logic [5:0] OP_BAD = 6'b111111;

   typedef struct {
      logic [5:0]  opc;
      logic [3:0]  st;
      logic [15:0] ctl;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n  [NDUT];
   logic [5:0]  opc_in [NDUT];
   logic [15:0] ctl_w  [NDUT];
   logic [3:0]  st_w   [NDUT];

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   generate
      for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
         localparam int MW = (gi == 0) ? 1 : ((gi == 1) ? 2 : 0);
         logic       pc_write, pc_write_cond, i_or_d, mem_write, ir_write;
         logic       reg_dst, mem_to_reg, reg_write, alu_src_a, trap;
         logic [1:0] pc_source, alu_src_b, alu_op;
         logic [3:0] state_out;

         control_unit_mc #(.MEM_WAIT(MW)) u_dut (
            .clk           (clk),
            .reset         (rst_n[gi]),
            .opcode        (opc_in[gi]),
            .pc_write      (pc_write),
            .pc_write_cond (pc_write_cond),
            .pc_source     (pc_source),
            .i_or_d        (i_or_d),
            .mem_write     (mem_write),
            .ir_write      (ir_write),
            .reg_dst       (reg_dst),
            .mem_to_reg    (mem_to_reg),
            .reg_write     (reg_write),
            .alu_src_a     (alu_src_a),
            .alu_src_b     (alu_src_b),
            .alu_op        (alu_op),
            .trap          (trap),
            .state_out     (state_out)
         );

         assign ctl_w[gi] = {pc_write, pc_write_cond, pc_source, i_or_d, mem_write,
                             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                             alu_src_b, alu_op, trap};
         assign st_w[gi]  = state_out;
      end
   endgenerate

   task automatic check(input int sel, input string name,
                        input logic [3:0] est, input logic [15:0] ectl);
      checks++;
      if (st_w[sel] !== est || ctl_w[sel] !== ectl) begin
         errors++;
         $display("FAIL %s dut%0d: state=%0d ctl=%016b, required state=%0d ctl=%016b",
                  name, sel, st_w[sel], ctl_w[sel], est, ectl);
      end else begin
         $display("ok   %s dut%0d: state=%0d ctl=%016b", name, sel, st_w[sel], ctl_w[sel]);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic [3:0] st, input logic [15:0] ctl);
      vec_t v;
      v.opc = op;
      v.st  = st;
      v.ctl = ctl;
      tbl.push_back(v);
   endtask

   // Entry vector 0 is checked immediately; later vectors one per negedge.
   task automatic run_table(input int sel, input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         if (i != 0) @(negedge clk);
         check(sel, $sformatf("%s[%0d]", name, i), tbl[i].st, tbl[i].ctl);
         opc_in[sel] = tbl[i].opc;
      end
      tbl.delete();
   endtask

   // Assert reset (possibly mid-cycle), hold 3 cycles, release on a negedge.
   task automatic do_reset(input int sel);
      rst_n[sel] = 1'b0;
      #1;
      check(sel, "rst_assert", S_FETCH, C_ZERO);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check(sel, $sformatf("rst_hold%0d", i), S_FETCH, C_ZERO);
      end
      rst_n[sel] = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NDUT; i++) begin
         rst_n[i]  = 1'b0;
         opc_in[i] = OP_BAD;
      end
      repeat (2) @(negedge clk);

      // ---- MEM_WAIT=1: R, sw, beq, j, addi, illegal ----
      do_reset(0);
      add(OP_BAD,   S_FETCH,     C_FW);
      add(OP_BAD,   S_FETCH,     C_FL);
      add(OP_RTYPE, S_DECODE,    C_DEC);
      add(OP_BAD,   S_EXEC_R,    C_EXR);
      add(OP_BAD,   S_R_WB,      C_RWB);
      add(OP_BAD,   S_FETCH,     C_FW);
      add(OP_BAD,   S_FETCH,     C_FL);
      add(OP_SW,    S_DECODE,    C_DEC);
      add(OP_LW,    S_MEM_ADDR,  C_MADDR);
      add(OP_BAD,   S_MEM_WRITE, C_MWR);
      add(OP_BAD,   S_FETCH,     C_FW);
      add(OP_BAD,   S_FETCH,     C_FL);
      add(OP_BEQ,   S_DECODE,    C_DEC);
      add(OP_BAD,   S_BRANCH,    C_BR);
      add(OP_BAD,   S_FETCH,     C_FW);
      add(OP_BAD,   S_FETCH,     C_FL);
      add(OP_J,     S_DECODE,    C_DEC);
      add(OP_BAD,   S_JUMP,      C_JMP);
      add(OP_BAD,   S_FETCH,     C_FW);
      add(OP_BAD,   S_FETCH,     C_FL);
      add(OP_ADDI,  S_DECODE,    C_DEC);
      add(OP_BAD,   S_ADDI_EXEC, C_AEX);
      add(OP_BAD,   S_ADDI_WB,   C_AWB);
      add(OP_RTYPE, S_FETCH,     C_FW);
      add(OP_RTYPE, S_FETCH,     C_FL);
      add(OP_BAD,   S_DECODE,    C_DEC);
      add(OP_RTYPE, S_TRAP,      C_TRAP);
      run_table(0, "mw1");

      // TRAP is absorbing regardless of opcode
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         opc_in[0] = 6'($urandom_range(0, 63));
         check(0, $sformatf("trap_hold%0d", i), S_TRAP, C_TRAP);
      end
      @(negedge clk);
      do_reset(0);
      add(OP_BAD, S_FETCH, C_FW);
      add(OP_BAD, S_FETCH, C_FL);
      run_table(0, "trap_exit");

      // ---- MEM_WAIT=2: lw, then sw interrupted by reset ----
      do_reset(1);
      add(OP_BAD, S_FETCH,     C_FW);
      add(OP_BAD, S_FETCH,     C_FW);
      add(OP_BAD, S_FETCH,     C_FL);
      add(OP_LW,  S_DECODE,    C_DEC);
      add(OP_SW,  S_MEM_ADDR,  C_MADDR);
      add(OP_BAD, S_MEM_READ,  C_MRD);
      add(OP_BAD, S_MEM_READ,  C_MRD);
      add(OP_BAD, S_MEM_READ,  C_MRD);
      add(OP_BAD, S_MEM_WB,    C_MWB);
      add(OP_BAD, S_FETCH,     C_FW);
      add(OP_BAD, S_FETCH,     C_FW);
      add(OP_BAD, S_FETCH,     C_FL);
      add(OP_SW,  S_DECODE,    C_DEC);
      add(OP_BAD, S_MEM_ADDR,  C_MADDR);
      add(OP_SW,  S_MEM_WRITE, C_MWR);
      run_table(1, "mw2");
      #2;
      do_reset(1);
      add(OP_SW,     S_FETCH,  C_FW);
      add(OP_SW,     S_FETCH,  C_FW);
      add(OP_SW,     S_FETCH,  C_FL);
      add(OP_RTYPE,  S_DECODE, C_DEC);
      add(OP_SW,     S_EXEC_R, C_EXR);
      add(OP_SW,     S_R_WB,   C_RWB);
      add(OP_SW,     S_FETCH,  C_FW);
      run_table(1, "post_rst");

      // ---- MEM_WAIT=0: single-cycle FETCH and MEM_READ ----
      do_reset(2);
      add(OP_BAD,   S_FETCH,    C_FL);
      add(OP_RTYPE, S_DECODE,   C_DEC);
      add(OP_BAD,   S_EXEC_R,   C_EXR);
      add(OP_BAD,   S_R_WB,     C_RWB);
      add(OP_BAD,   S_FETCH,    C_FL);
      add(OP_LW,    S_DECODE,   C_DEC);
      add(OP_BAD,   S_MEM_ADDR, C_MADDR);
      add(OP_BAD,   S_MEM_READ, C_MRD);
      add(OP_BAD,   S_MEM_WB,   C_MWB);
      add(OP_BAD,   S_FETCH,    C_FL);
      run_table(2, "mw0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
